csb_sequencer: RTL and testbench
================================

Name: csb_sequencer

Overview:
- Command sequencing block directly upstream of the compute engine.
- Buffers layer commands (op_type, op_num) pushed by the host/DMA side and issues them one at a time to the engine.
- Issue uses the conv_ready/maxpool_ready/avepool_ready handshake and waits for the matching *_valid before advancing.
- Reports busy/done/error status back to the host.

Parameters:
- CMD_DEPTH, 16, command queue entries (power of 2, ≥2).
- TIMEOUT, 0, max cycles waiting for *_valid before error; 0 disables timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_wr_en  in  1  push command into queue
- cmd_op_type  in  3  command op type
- cmd_op_num  in  32  command op count
- cmd_full  out  1  queue full
- cmd_empty  out  1  queue empty
- start  in  1  single-cycle pulse: begin draining queue
- conv_ready  out  1  issue conv op to engine
- maxpool_ready  out  1  issue maxpool op
- avepool_ready  out  1  issue avepool op
- op_type  out  3  op type presented to engine
- op_num  out  32  op count presented to engine
- conv_valid  in  1  engine finished conv
- maxpool_valid  in  1  engine finished maxpool
- avepool_valid  in  1  engine finished avepool
- busy  out  1  sequencer running
- done  out  1  one-cycle pulse when queue drained
- err  out  1  sticky: illegal op, overflow or timeout
- cmd_count  out  16  commands completed since last start (wraps at 65535→0)

Behaviour:
- Reset (async, immediate): queue flushed (cmd_empty=1, cmd_full=0); all ready/busy/done/err=0; op_type=0, op_num=0, cmd_count=0; FSM→IDLE. Applies equally when asserted mid-operation.
- Queue: synchronous FIFO.
  - Push when cmd_wr_en & !cmd_full.
  - Push while full is dropped and sets err.
  - Pushes are accepted in any state, including while busy.
- Op decoding:
  - 1, 2 → conv_ready.
  - 3, 4 → maxpool_ready.
  - 5 → avepool_ready.
  - 0 → NOP: popped, counted, no handshake.
  - 6, 7 → illegal: popped, not counted, err set, skipped.
- FSM states: IDLE, FETCH, ISSUE, WAIT_LOW, DONE.
  - IDLE: start sampled high → FETCH, busy=1, cmd_count=0. Start while busy is ignored.
  - FETCH, queue empty → DONE.
  - FETCH, queue not empty → pop head into op_type/op_num registers. Legal non-NOP → ISSUE; NOP/illegal → FETCH (next pop the following cycle).
  - ISSUE: the selected *_ready is high (registered). Exactly one ready is high at a time. op_type/op_num are stable for the entire time ready is high.
  - ISSUE → WAIT_LOW: on the cycle the matching *_valid is sampled high, ready drops next edge and cmd_count increments. *_valid lines not matching the issued op are ignored.
  - WAIT_LOW: wait until the matching *_valid is low, then → FETCH. If valid is already low, leave after 1 cycle. This prevents a held valid from completing the next command.
  - DONE: done=1 for one cycle, busy=0, → IDLE. op_type/op_num retain their last values.
- Latency:
  - start at edge N → ready high after edge N+2.
  - valid at edge M → ready low after edge M+1.
  - Next ready high no earlier than edge M+3 (valid low at M+1).
- Timeout (TIMEOUT>0): counter runs while in ISSUE. On reaching TIMEOUT: set err, drop ready, flush queue, → DONE.
- err clears only on reset or on a start accepted in IDLE.

Test Plan:
- Push {2,9}, start → op_type=2, op_num=9, conv_ready high 2 cycles after start. Engine pulses conv_valid 30 cycles later → conv_ready low next cycle, cmd_count=1, done pulse, busy=0.
- Push {2,9},{5,169},{3,4}, start → conv, avepool, maxpool readies in order, never overlapping. cmd_count=3. Single done pulse.
- Engine holds avepool_valid high 5 cycles after completion; queue holds {5,169},{5,169} → second avepool_ready rises only after valid falls.
- Push {0,7},{6,1},{5,169} → no handshake for the first two, err=1, avepool issued, cmd_count=2.
- Push 17 commands with CMD_DEPTH=16 → cmd_full after 16, err=1. Also: TIMEOUT=50 with no conv_valid → ready drops at cycle 50, queue empty, done pulses.
- Assert rst while conv_ready high → ready/busy/op_num clear immediately without a clock edge, cmd_empty=1.

Source files
------------

// File: rtl/csb_sequencer.sv
// Command sequencer: queues host layer commands and hands them to the compute engine one at a time.
// Latency: ready rises two edges after start and falls one edge after the matching valid is sampled.
// Backpressure: host pushes into a full queue are dropped and flagged in err; the engine paces issue via *_valid.
module csb_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdat,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdat    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdat;
  end
endmodule

module csb_sequencer #(
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_wr_en,
  input  logic [2:0]  cmd_op_type,
  input  logic [31:0] cmd_op_num,
  output logic        cmd_full,
  output logic        cmd_empty,
  input  logic        start,
  output logic        conv_ready,
  output logic        maxpool_ready,
  output logic        avepool_ready,
  output logic [2:0]  op_type,
  output logic [31:0] op_num,
  input  logic        conv_valid,
  input  logic        maxpool_valid,
  input  logic        avepool_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cmd_count
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_LOW, DONE} state_t;

  localparam logic [1:0] CL_NONE = 2'd0;
  localparam logic [1:0] CL_CONV = 2'd1;
  localparam logic [1:0] CL_MAX  = 2'd2;
  localparam logic [1:0] CL_AVE  = 2'd3;

  function automatic logic [1:0] op_class(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: op_class = CL_CONV;
      3'd3, 3'd4: op_class = CL_MAX;
      3'd5:       op_class = CL_AVE;
      default:    op_class = CL_NONE;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [34:0] head;
  logic [2:0]  head_type;
  logic [1:0]  head_class, cur_class;
  logic        head_nop, head_illegal;
  logic        pop, start_acc, match_vld, any_ready, complete, timeout_hit;
  logic [31:0] timer;

  csb_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(35)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_wr_en),
    .pop   (pop),
    .flush (timeout_hit),
    .wdat  ({cmd_op_type, cmd_op_num}),
    .rdat  (head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  assign head_type    = head[34:32];
  assign head_class   = op_class(head_type);
  assign head_nop     = (head_type == 3'd0);
  assign head_illegal = head_type[2] & head_type[1];
  assign cur_class    = op_class(op_type);
  assign pop          = (state == FETCH) && !cmd_empty;
  assign start_acc    = (state == IDLE) && start;
  assign any_ready    = conv_ready | maxpool_ready | avepool_ready;
  // Completion only counts once ready is actually visible to the engine.
  assign complete     = (state == ISSUE) && any_ready && match_vld;
  assign timeout_hit  = (TIMEOUT > 0) && (state == ISSUE) && !complete && (timer == 32'(TIMEOUT));

  always_comb begin
    match_vld = 1'b0;
    case (cur_class)
      CL_CONV: match_vld = conv_valid;
      CL_MAX:  match_vld = maxpool_valid;
      CL_AVE:  match_vld = avepool_valid;
      default: match_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FETCH;
      FETCH:    if (cmd_empty) state_nxt = DONE;
                else if (head_class != CL_NONE) state_nxt = ISSUE;
      ISSUE:    if (complete) state_nxt = WAIT_LOW;
                else if (timeout_hit) state_nxt = DONE;
      WAIT_LOW: if (!match_vld) state_nxt = FETCH;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      FETCH, ISSUE, WAIT_LOW: busy = 1'b1;
      DONE:                   done = 1'b1;
      default:                busy = 1'b0;
    endcase
  end

  // Ready trails ISSUE by one edge, so it stays up through the completion cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_type       <= '0;
      op_num        <= '0;
      conv_ready    <= 1'b0;
      maxpool_ready <= 1'b0;
      avepool_ready <= 1'b0;
      cmd_count     <= '0;
      err           <= 1'b0;
      timer         <= '0;
    end else begin
      if (pop) begin
        op_type <= head_type;
        op_num  <= head[31:0];
      end
      conv_ready    <= (state == ISSUE) && !timeout_hit && (cur_class == CL_CONV);
      maxpool_ready <= (state == ISSUE) && !timeout_hit && (cur_class == CL_MAX);
      avepool_ready <= (state == ISSUE) && !timeout_hit && (cur_class == CL_AVE);
      timer         <= (state == ISSUE) ? timer + 32'd1 : 32'd0;
      if (start_acc)
        cmd_count <= '0;
      else if (complete || (pop && head_nop))
        cmd_count <= cmd_count + 16'd1;
      if ((cmd_wr_en && cmd_full) || (pop && head_illegal) || timeout_hit)
        err <= 1'b1;
      else if (start_acc)
        err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_csb_sequencer.sv
// Bench for csb_sequencer: acts as host and engine, checks issue order, handshake timing and status.
module tb_csb_sequencer;
  localparam int DEPTH = 16;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_wr_en;
  logic [2:0]  cmd_op_type;
  logic [31:0] cmd_op_num;
  logic        cmd_full, cmd_empty, start;
  logic        conv_ready, maxpool_ready, avepool_ready;
  logic [2:0]  op_type;
  logic [31:0] op_num;
  logic        conv_valid, maxpool_valid, avepool_valid;
  logic        busy, done, err;
  logic [15:0] cmd_count;
  logic [2:0]  rdy, vdrv;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [34:0] mq[$];
  logic        exp_err;

  assign rdy = {conv_ready, maxpool_ready, avepool_ready};
  assign {conv_valid, maxpool_valid, avepool_valid} = vdrv;

  csb_sequencer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_wr_en     (cmd_wr_en),
    .cmd_op_type   (cmd_op_type),
    .cmd_op_num    (cmd_op_num),
    .cmd_full      (cmd_full),
    .cmd_empty     (cmd_empty),
    .start         (start),
    .conv_ready    (conv_ready),
    .maxpool_ready (maxpool_ready),
    .avepool_ready (avepool_ready),
    .op_type       (op_type),
    .op_num        (op_num),
    .conv_valid    (conv_valid),
    .maxpool_valid (maxpool_valid),
    .avepool_valid (avepool_valid),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cmd_count     (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ready/valid line expected for an op type, ordered {conv, maxpool, avepool}.
  function automatic logic [2:0] exp_mask(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 3'b100;
    if (t == 3'd3 || t == 3'd4) return 3'b010;
    if (t == 3'd5) return 3'b001;
    return 3'b000;
  endfunction

  task automatic push(input logic [2:0] t, input logic [31:0] n);
    cmd_wr_en   = 1'b1;
    cmd_op_type = t;
    cmd_op_num  = n;
    tick();
    cmd_wr_en = 1'b0;
    if (mq.size() < DEPTH) mq.push_back({t, n});
    else exp_err = 1'b1;
    check("cmd_full", 32'(cmd_full), 32'(mq.size() == DEPTH));
    check("cmd_empty", 32'(cmd_empty), 0);
    check("err_after_push", 32'(err), 32'(exp_err));
  endtask

  task automatic do_start(output int sc);
    sc    = cyc;
    start = 1'b1;
    tick();
    start   = 1'b0;
    exp_err = 1'b0;
    check("busy_start", 32'(busy), 1);
    check("err_clear", 32'(err), 0);
  endtask

  // Plays the engine until done, checking each issue against the queued commands.
  task automatic drain(input int sc, input int dmin, input int dmax, input int hold,
                       input bit respond, input bit noise, input bit poke);
    logic [34:0] iq[$];
    logic [34:0] e, last;
    logic [2:0]  t, cur, prev, vmask, nmask, imask;
    int          exp_cnt, wait_cnt, hold_left, val_cyc, low_cyc, rise_cyc, issued;
    bit          tmo, dense, first_issue, got_done, have_last;
    exp_cnt = 0; tmo = 1'b0; dense = 1'b1; have_last = 1'b0; last = '0;
    first_issue = 1'b0;
    if (mq.size() > 0) begin
      e = mq[0];
      first_issue = (exp_mask(e[34:32]) != 3'b000);
    end
    foreach (mq[i]) begin
      e = mq[i];
      t = e[34:32];
      if (exp_mask(t) == 3'b000) dense = 1'b0;
      if (!tmo) begin
        last = e;
        have_last = 1'b1;
        if (t == 3'd0) exp_cnt++;
        else if (t >= 3'd6) exp_err = 1'b1;
        else begin
          iq.push_back(e);
          if (respond) exp_cnt++;
          else tmo = 1'b1;
        end
      end
    end
    if (tmo) exp_err = 1'b1;
    mq.delete();

    prev = '0; vmask = '0; nmask = '0; imask = '0;
    wait_cnt = -1; hold_left = 0; val_cyc = 0; low_cyc = 0; rise_cyc = 0;
    issued = 0; got_done = 1'b0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      tick();
      start = 1'b0;
      cur = rdy;
      check("ready_onehot", 32'($countones(cur) <= 1), 1);
      if (cur != 3'b000 && prev == 3'b000) begin
        if (iq.size() == 0) check("spurious_ready", 32'(cur), 0);
        else begin
          e = iq.pop_front();
          imask = exp_mask(e[34:32]);
          check("ready_sel", 32'(cur), 32'(imask));
          check("op_type", 32'(op_type), 32'(e[34:32]));
          check("op_num", op_num, e[31:0]);
          check("busy_run", 32'(busy), 1);
          if (issued == 0 && first_issue) check("start_lat", 32'(cyc - sc), 3);
          if (issued > 0 && dense) check("reissue_gap", 32'(cyc - low_cyc), 3);
          if (issued > 0 && !dense) check("reissue_min", 32'(cyc - low_cyc >= 3), 1);
          if (poke && issued == 0) start = 1'b1;
          issued++;
          rise_cyc = cyc;
          wait_cnt = respond ? int'($urandom_range(dmax, dmin)) : -1;
        end
      end
      if (cur == 3'b000 && prev != 3'b000) begin
        if (respond) check("ready_fall_lat", 32'(cyc - val_cyc), 2);
        else check("timeout_len", 32'(cyc - rise_cyc), TMO);
      end
      if (done) begin
        got_done = 1'b1;
        check("busy_at_done", 32'(busy), 0);
        check("cmd_count", 32'(cmd_count), 32'(exp_cnt));
        check("err_at_done", 32'(err), 32'(exp_err));
        check("queue_empty", 32'(cmd_empty), 1);
        check("issues_left", 32'(iq.size()), 0);
        if (have_last) begin
          check("op_num_hold", op_num, last[31:0]);
          check("op_type_hold", 32'(op_type), 32'(last[34:32]));
        end
      end
      if (wait_cnt > 0) wait_cnt--;
      else if (wait_cnt == 0) begin
        vmask = imask; hold_left = hold; val_cyc = cyc; wait_cnt = -1;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          vmask = '0;
          low_cyc = cyc;
        end
      end
      nmask = (noise && cur != 3'b000) ? (3'($urandom) & ~imask) : 3'b000;
      vdrv = vmask | nmask;
      prev = cur;
    end
    if (!got_done) check("done_seen", 0, 1);
    vdrv = '0;
    tick();
    check("done_pulse", 32'(done), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int sc, n;
    rst = 1'b1; cmd_wr_en = 1'b0; cmd_op_type = '0; cmd_op_num = '0;
    start = 1'b0; vdrv = '0; exp_err = 1'b0;
    tick();
    tick();
    check("rst_empty", 32'(cmd_empty), 1);
    check("rst_full", 32'(cmd_full), 0);
    check("rst_ready", 32'(rdy), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_op_type", 32'(op_type), 0);
    check("rst_op_num", op_num, 0);
    check("rst_count", 32'(cmd_count), 0);
    rst = 1'b0;
    tick();

    // single conv, engine answers 30 cycles after ready
    push(3'd2, 32'd9);
    do_start(sc);
    drain(sc, 30, 30, 1, 1'b1, 1'b0, 1'b0);

    // three ops in order, stray valids on other lines, start pulse while busy
    push(3'd2, 32'd9); push(3'd5, 32'd169); push(3'd3, 32'd4);
    do_start(sc);
    drain(sc, 0, 20, 1, 1'b1, 1'b1, 1'b1);

    // valid held long after completion must not retire the next command
    push(3'd5, 32'd169); push(3'd5, 32'd169);
    do_start(sc);
    drain(sc, 2, 5, 6, 1'b1, 1'b0, 1'b0);

    // NOP and illegal entries
    push(3'd0, 32'd7); push(3'd6, 32'd1); push(3'd5, 32'd169);
    do_start(sc);
    drain(sc, 0, 10, 1, 1'b1, 1'b0, 1'b0);

    // start with an empty queue
    do_start(sc);
    drain(sc, 0, 0, 1, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(10, 1));
      for (int i = 0; i < n; i++) push(3'($urandom_range(7, 0)), $urandom);
      do_start(sc);
      drain(sc, 0, 40, int'($urandom_range(4, 1)), 1'b1, 1'b1, r == 0);
    end

    // overflow: 17th push is dropped and flagged
    for (int i = 0; i < DEPTH + 1; i++) push(3'($urandom_range(5, 0)), $urandom);
    do_start(sc);
    drain(sc, 0, 3, 1, 1'b1, 1'b1, 1'b0);

    // engine never answers: timeout drops ready, flushes queue, ends run
    push(3'd1, 32'd77); push(3'd5, 32'd3); push(3'd0, 32'd1);
    do_start(sc);
    drain(sc, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    check("tmo_flushed", 32'(cmd_empty), 1);

    // asynchronous reset in the middle of an issue
    push(3'd1, 32'hABCD);
    do_start(sc);
    for (int k = 0; k < 10 && !conv_ready; k++) tick();
    check("pre_rst_ready", 32'(conv_ready), 1);
    check("pre_rst_op_num", op_num, 32'hABCD);
    push(3'd2, 32'd5);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", 32'(rdy), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_op_num", op_num, 0);
    check("arst_op_type", 32'(op_type), 0);
    check("arst_empty", 32'(cmd_empty), 1);
    check("arst_count", 32'(cmd_count), 0);
    check("arst_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    mq.delete();
    exp_err = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
